// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//   Time-shares one combinational ALU between NUM_REQ requesters. A round-robin
//   grant is issued in IDLE. The winner's opcode and operands are latched onto
//   the ALU drive registers and the ALU runs for one full cycle (EXEC). Its
//   result and branch flag are then registered and held on a valid/ready
//   response port (RESP) together with the id of the owning requester. Only one
//   transaction is in flight at a time.
//
// Ports
//   clk, rst_n    clock; synchronous active-low reset
//   req_valid     per-requester request valid
//   req_ready     per-requester accept (one-hot or zero, IDLE only)
//   req_op/a/b    packed per-requester opcode / r0 / r1, requester i at slot i
//   alu_op/r0/r1  latched drive to the shared ALU
//   alu_o_data    ALU result input
//   alu_b_pcsrc   ALU branch flag input
//   rsp_valid     response valid
//   rsp_ready     response accept
//   rsp_id        requester index that owns the response
//   rsp_data      registered ALU result
//   rsp_branch    registered ALU branch flag
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter  int NUM_REQ = 2,
    parameter  int DATA_W  = 8,
    parameter  int OP_W    = 7,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [OP_W-1:0]           alu_op,
    output logic [DATA_W-1:0]         alu_r0,
    output logic [DATA_W-1:0]         alu_r1,
    input  logic [DATA_W-1:0]         alu_o_data,
    input  logic                      alu_b_pcsrc,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_branch
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] grant_next_ptr;
    logic [ID_W-1:0] probe;
    logic            found;
    logic            accept;

    // Round-robin search: start at rr_ptr and take the first valid requester,
    // wrapping modulo NUM_REQ (which need not be a power of two).
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        found = 1'b0;
        grant = '0;
        probe = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            probe = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[probe]) begin
                found = 1'b1;
                grant = probe;
            end
        end
    end

    assign grant_next_ptr = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);

    // Next-state and handshake outputs. req_ready is also gated by rst_n so
    // that nothing looks accepted on a reset edge.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    accept           = 1'b1;
                    req_ready[grant] = rst_n;
                    state_next       = EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the reset
    // branch sits inside the clocked block because reset is synchronous.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ALU drive registers change only at an accept edge; the response
    // registers capture the ALU output at the end of EXEC and hold in RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            alu_op     <= '0;
            alu_r0     <= '0;
            alu_r1     <= '0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_branch <= 1'b0;
        end else begin
            if (accept) begin
                alu_op <= req_op[int'(grant)*OP_W +: OP_W];
                alu_r0 <= req_a[int'(grant)*DATA_W +: DATA_W];
                alu_r1 <= req_b[int'(grant)*DATA_W +: DATA_W];
                rsp_id <= grant;
                rr_ptr <= grant_next_ptr;
            end
            if (state == EXEC) begin
                rsp_data   <= alu_o_data;
                rsp_branch <= alu_b_pcsrc;
            end
        end
    end

    assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//   Self-checking bench. A behavioural ALU drives the DUT's ALU port. A
//   cycle-level reference model predicts req_ready, rsp_valid and the ALU drive
//   values, and pushes the expected response into a scoreboard whenever it
//   predicts an accept. A separate monitor compares every presented response
//   against the scoreboard head and pops it on the handshake.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int N  = 2;
    localparam int DW = 8;
    localparam int OW = 7;
    localparam int IW = $clog2(N);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*OW-1:0]   req_op = '0;
    logic [N*DW-1:0]   req_a = '0;
    logic [N*DW-1:0]   req_b = '0;
    logic [OW-1:0]     alu_op;
    logic [DW-1:0]     alu_r0;
    logic [DW-1:0]     alu_r1;
    logic [DW-1:0]     alu_o_data;
    logic              alu_b_pcsrc;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [IW-1:0]     rsp_id;
    logic [DW-1:0]     rsp_data;
    logic              rsp_branch;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .alu_op      (alu_op),
        .alu_r0      (alu_r0),
        .alu_r1      (alu_r1),
        .alu_o_data  (alu_o_data),
        .alu_b_pcsrc (alu_b_pcsrc),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_branch  (rsp_branch)
    );

    // Golden ALU: returns {branch, result}.
    function automatic logic [DW:0] golden(input logic [OW-1:0] op,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
        logic [DW-1:0] r;
        logic          br;
        case (op[2:0])
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = a << b[2:0];
            3'd6:    r = a >> b[2:0];
            default: r = b;
        endcase
        if (op[6])      br = (a == b);
        else if (op[5]) br = (a < b);
        else            br = 1'b0;
        return {br, r};
    endfunction

    assign {alu_b_pcsrc, alu_o_data} = golden(alu_op, alu_r0, alu_r1);

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        logic          br;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_acc  = 0;
    int   n_drop = 0;
    int   n_rsp  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time; a response becomes visible
    // one edge after the accept and retires at the first edge with rsp_ready.
    int            m_rr   = 0;
    bit            m_busy = 1'b0;
    int            m_age  = 0;
    logic [OW-1:0] m_op   = '0;
    logic [DW-1:0] m_a    = '0;
    logic [DW-1:0] m_b    = '0;
    int            m_idx;
    int            m_g;
    bit            m_any;
    logic [N-1:0]  m_ready;
    logic [DW:0]   m_res;

    always @(negedge clk) begin
        m_any = 1'b0;
        m_g   = 0;
        for (int k = 0; k < N; k++) begin
            m_idx = (m_rr + k) % N;
            if (!m_any && req_valid[m_idx]) begin
                m_any = 1'b1;
                m_g   = m_idx;
            end
        end
        m_ready = '0;
        if (rst_n && !m_busy && m_any) m_ready[m_g] = 1'b1;

        check("req_ready", 32'(req_ready), 32'(m_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age >= 1));
        check("alu_op",    32'(alu_op),    32'(m_op));
        check("alu_r0",    32'(alu_r0),    32'(m_a));
        check("alu_r1",    32'(alu_r1),    32'(m_b));

        if (!rst_n) begin
            n_drop += sb.size();
            sb.delete();
            m_busy = 1'b0;
            m_age  = 0;
            m_rr   = 0;
            m_op   = '0;
            m_a    = '0;
            m_b    = '0;
        end else if (m_busy) begin
            if (m_age >= 1 && rsp_ready) m_busy = 1'b0;
            else if (m_age < 1)          m_age++;
        end else if (m_any) begin
            m_op   = req_op[m_g*OW +: OW];
            m_a    = req_a[m_g*DW +: DW];
            m_b    = req_b[m_g*DW +: DW];
            m_res  = golden(m_op, m_a, m_b);
            sb.push_back('{id: m_g, data: m_res[DW-1:0], br: m_res[DW]});
            m_busy = 1'b1;
            m_age  = 0;
            m_rr   = (m_g + 1) % N;
            n_acc++;
        end
    end

    // Monitor: every presented response must match the scoreboard head and
    // stay stable until its handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'(0));
            end else begin
                check("rsp_id",     32'(rsp_id),     32'(sb[0].id));
                check("rsp_data",   32'(rsp_data),   32'(sb[0].data));
                check("rsp_branch", 32'(rsp_branch), 32'(sb[0].br));
                if (rsp_ready) begin
                    void'(sb.pop_front());
                    n_rsp++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [OW-1:0] op,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_op[i*OW +: OW] = op;
        req_a[i*DW +: DW]  = a;
        req_b[i*DW +: DW]  = b;
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((m_busy || sb.size() != 0) && c < budget) begin
            step();
            c++;
        end
        check("drain_timeout", 32'(m_busy || sb.size() != 0), 32'(0));
    endtask

    initial begin
        int cyc;

        // Reset with every requester asking.
        req_valid = '1;
        set_req(0, 7'h11, 8'hAA, 8'h55);
        set_req(1, 7'h22, 8'h0F, 8'hF0);
        repeat (2) step();
        check("rst_req_ready",  32'(req_ready),  32'(0));
        check("rst_rsp_valid",  32'(rsp_valid),  32'(0));
        check("rst_rsp_id",     32'(rsp_id),     32'(0));
        check("rst_rsp_data",   32'(rsp_data),   32'(0));
        check("rst_rsp_branch", 32'(rsp_branch), 32'(0));
        req_valid = '0;
        rst_n     = 1'b1;
        step();

        // Single request from requester 0.
        set_req(0, 7'h05, 8'h12, 8'h34);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        step();
        req_valid = '0;
        check("single_alu_op", 32'(alu_op), 32'h05);
        step();
        check("single_rsp_valid", 32'(rsp_valid), 32'(1));
        check("single_rsp_data",  32'(rsp_data),  32'h20);
        drain(20);

        // Contention: both requesters valid continuously.
        set_req(0, 7'h40, 8'h33, 8'h33);
        set_req(1, 7'h21, 8'h10, 8'h20);
        req_valid = 2'b11;
        repeat (13) step();
        req_valid = '0;
        drain(20);

        // Backpressure: hold the response for 10 cycles.
        set_req(1, 7'h03, 8'hC0, 8'h0C);
        req_valid = 2'b10;
        rsp_ready = 1'b0;
        step();
        req_valid = 2'b11;
        step();
        repeat (10) step();
        rsp_ready = 1'b1;
        step();
        step();
        req_valid = '0;
        drain(20);

        // Reset during EXEC drops the transaction and rewinds the pointer.
        set_req(0, 7'h00, 8'h01, 8'h02);
        req_valid = 2'b01;
        step();
        req_valid = '0;
        rst_n     = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
        set_req(1, 7'h06, 8'h80, 8'h03);
        req_valid = 2'b10;
        step();
        req_valid = '0;
        drain(20);

        // Randomized traffic.
        cyc = 0;
        while (n_acc < 5000 && cyc < 60000) begin
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(0, 3) != 0);
                set_req(i, OW'($urandom), DW'($urandom), DW'($urandom));
            end
            rsp_ready = $urandom_range(0, 1) != 0;
            step();
            cyc++;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        drain(20);
        check("accept_count_reached", 32'(n_acc >= 5000), 32'(1));
        check("response_count",       32'(n_rsp),        32'(n_acc - n_drop));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
